// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: load-use bubbles, memory-wait freeze and
// taken-branch squash, with saturating stall/flush counters and a sticky timeout flag.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_uses_src2,
    input  logic             id_branch_tkn,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             hazard_detected,
    output logic             pipe_freeze,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       set_err;
    logic       luse;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign luse = ex_mem_read && (ex_write_reg != '0) &&
                  ((ex_write_reg == id_src1) ||
                   (id_uses_src2 && (ex_write_reg == id_src2)));

    always_comb begin
        // NOTE: every output gets a default before any branch so no path infers a latch.
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        set_err         = 1'b0;
        pc_write        = 1'b1;
        ifid_write      = 1'b1;
        ifid_flush      = 1'b0;
        hazard_detected = 1'b0;
        pipe_freeze     = 1'b0;

        if (!rst_n) begin
            // Held in reset: bubble into ID/EX, keep PC and IF/ID still.
            pc_write        = 1'b0;
            ifid_write      = 1'b0;
            hazard_detected = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        pipe_freeze  = 1'b1;
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        state_nxt    = MEM_WAIT;
                        wait_cnt_nxt = 8'd1;
                    end else if (luse) begin
                        pc_write        = 1'b0;
                        ifid_write      = 1'b0;
                        hazard_detected = 1'b1;
                    end else if (id_branch_tkn) begin
                        ifid_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    if (mem_ready) begin
                        state_nxt    = RUN;
                        wait_cnt_nxt = 8'd0;
                    end else if (wait_cnt == TIMEOUT) begin
                        set_err      = 1'b1;
                        state_nxt    = RUN;
                        wait_cnt_nxt = 8'd0;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err | set_err;
            if (!pc_write && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
